mdma_ram_fifo_ctl: RTL and testbench

- Master-side controller for the 18b x 2048 ECC-protected RAM. Turns the RAM into a valid/ready streaming FIFO.
- Accepts words from an upstream producer, writes them to the RAM, and issues reads with credit-based prefetch. Returned data lands in a small output buffer, which hides the RAM read latency.
- Reports ECC single-bit events (counted) and double-bit events (flagged per word and sticky).
- Sits between an MDMA datapath stage and the RAM slave, driving the RAM's write/read address, enable and data signals.

---
 rtl/mdma_ram_fifo_pkg.sv | 11 +
 rtl/mdma_ram_fifo_obuf.sv | 46 ++++
 rtl/mdma_ram_fifo_ctl.sv | 136 +++++++++++++
 tb/tb_mdma_ram_fifo_ctl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdma_ram_fifo_pkg.sv
// Shared defaults and types for the MDMA RAM-backed streaming FIFO controller.
package mdma_ram_fifo_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 18;
    localparam int SBE_CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] dat;
        logic                  dbe;
    } obuf_entry_t;
endpackage

// File: rtl/mdma_ram_fifo_obuf.sv
// Small first-word-fall-through register FIFO that absorbs RAM read returns.
module mdma_ram_fifo_obuf #(
    parameter int DEPTH = 4,
    parameter int W     = 19,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);

    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && cnt == CNT_W'(DEPTH)));
endmodule

// File: rtl/mdma_ram_fifo_ctl.sv
// Streaming valid/ready FIFO built on an external ECC RAM with credit-based read prefetch.
module mdma_ram_fifo_ctl
    import mdma_ram_fifo_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 2,
    parameter int OBUF_DEPTH = RD_LAT + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [DATA_W-1:0]    in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DATA_W-1:0]    out_dat,
    output logic                 out_dbe,
    output logic [ADDR_W-1:0]    ram_wadr,
    output logic                 ram_wen,
    output logic [DATA_W-1:0]    ram_wdat,
    output logic                 ram_ren,
    output logic [ADDR_W-1:0]    ram_radr,
    input  logic [DATA_W-1:0]    ram_rdat,
    input  logic                 ram_rsbe,
    input  logic                 ram_rdbe,
    input  logic                 clr_err,
    output logic [ADDR_W:0]      occupancy,
    output logic [SBE_CNT_W-1:0] sbe_cnt,
    output logic                 dbe_seen
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int OCNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int CRED_W = OCNT_W + 1;

    logic              accept;
    logic              pop;
    logic              tail;
    logic              ret_sbe;
    logic              ret_dbe;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  pend;
    logic [CNT_W-1:0]  pend_nxt;
    logic [CNT_W-1:0]  avail;
    logic [RD_LAT-1:0] vpipe;
    logic [OCNT_W-1:0] inflight;
    logic [OCNT_W-1:0] obuf_cnt;
    logic              obuf_empty;
    obuf_entry_t       push_ent;
    obuf_entry_t       head_ent;

    function automatic logic [SBE_CNT_W-1:0] sat_inc(input logic [SBE_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign accept   = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;
    assign tail     = vpipe[RD_LAT-1];
    assign ret_dbe  = tail & ram_rdbe;
    assign ret_sbe  = tail & ram_rsbe & ~ram_rdbe;
    assign pend_nxt = pend + CNT_W'(accept) - CNT_W'(ram_ren);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCNT_W'(vpipe[i]);
    end

    // Credits cover both in-flight reads and buffered words, so returns always find room.
    assign ram_ren  = (avail != '0) &&
                      ((CRED_W'(inflight) + CRED_W'(obuf_cnt)) < CRED_W'(OBUF_DEPTH));
    assign ram_radr = rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_rdy    <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            ram_wen   <= 1'b0;
            ram_wadr  <= '0;
            ram_wdat  <= '0;
            pend      <= '0;
            avail     <= '0;
            vpipe     <= '0;
            occupancy <= '0;
        end else begin
            in_rdy  <= (pend_nxt < CNT_W'(DEPTH));
            ram_wen <= accept;
            if (accept) begin
                ram_wadr <= wptr;
                ram_wdat <= in_dat;
                wptr     <= wptr + 1'b1;
            end
            pend  <= pend_nxt;
            avail <= avail + CNT_W'(ram_wen) - CNT_W'(ram_ren);
            if (ram_ren) rptr <= rptr + 1'b1;
            vpipe     <= (vpipe << 1) | RD_LAT'(ram_ren);
            occupancy <= occupancy + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // A same-cycle error outranks clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt  <= '0;
            dbe_seen <= 1'b0;
        end else begin
            if (ret_sbe)      sbe_cnt <= clr_err ? SBE_CNT_W'(1) : sat_inc(sbe_cnt);
            else if (clr_err) sbe_cnt <= '0;
            if (ret_dbe)      dbe_seen <= 1'b1;
            else if (clr_err) dbe_seen <= 1'b0;
        end
    end

    assign push_ent.dat = ram_rdat;
    assign push_ent.dbe = ram_rdbe;

    mdma_ram_fifo_obuf #(
        .DEPTH (OBUF_DEPTH),
        .W     ($bits(obuf_entry_t))
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tail),
        .push_dat (push_ent),
        .pop      (pop),
        .head     (head_ent),
        .cnt      (obuf_cnt),
        .empty    (obuf_empty)
    );

    assign out_vld = ~obuf_empty;
    assign out_dat = out_vld ? head_ent.dat : '0;
    assign out_dbe = out_vld & head_ent.dbe;
endmodule

// File: tb/tb_mdma_ram_fifo_ctl.sv
// Bench for mdma_ram_fifo_ctl: behavioural ECC RAM, scoreboard and directed sequences.
module tb_mdma_ram_fifo_ctl;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 18;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int OBUF   = RD_LAT + 2;
    localparam int NSTREAM = 65540;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [DATA_W-1:0] in_dat = '0;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [DATA_W-1:0] out_dat;
    logic              out_dbe;
    logic [ADDR_W-1:0] ram_wadr;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_wdat;
    logic              ram_ren;
    logic [ADDR_W-1:0] ram_radr;
    logic [DATA_W-1:0] ram_rdat;
    logic              ram_rsbe;
    logic              ram_rdbe;
    logic              clr_err = 1'b0;
    logic [ADDR_W:0]   occupancy;
    logic [15:0]       sbe_cnt;
    logic              dbe_seen;

    mdma_ram_fifo_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_dbe(out_dbe),
        .ram_wadr(ram_wadr), .ram_wen(ram_wen), .ram_wdat(ram_wdat), .ram_ren(ram_ren),
        .ram_radr(ram_radr), .ram_rdat(ram_rdat), .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe),
        .clr_err(clr_err), .occupancy(occupancy), .sbe_cnt(sbe_cnt), .dbe_seen(dbe_seen)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    int first_acc = -1;
    int first_out = -1;
    logic lat_arm = 1'b0;
    logic cur_sbe = 1'b0, cur_dbe = 1'b0, cur_exp = 1'b0;
    logic force_sbe = 1'b0;
    logic wwrap = 1'b0, rwrap = 1'b0;
    logic [ADDR_W-1:0] last_wadr = '0, last_radr = '0;

    logic [DATA_W:0]   exp_q [$];
    logic [1:0]        err_q [$];

    // RAM model: registered read pipeline, junk with error flags set when no return is due.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pd [RD_LAT];
    logic              pv [RD_LAT];
    logic              ps [RD_LAT];
    logic              pb [RD_LAT];

    initial for (int i = 0; i < RD_LAT; i++) pv[i] = 1'b0;

    always @(posedge clk) begin
        logic [1:0] e;
        e = 2'b00;
        if (ram_wen) mem[ram_wadr] <= ram_wdat;
        if (!rst_n) err_q.delete();
        else if (ram_ren && err_q.size() > 0) e = err_q.pop_front();
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
            pb[i] <= pb[i-1];
        end
        pd[0] <= mem[ram_radr];
        pv[0] <= ram_ren;
        ps[0] <= e[1] | force_sbe;
        pb[0] <= e[0];
    end

    assign ram_rdat = pv[RD_LAT-1] ? pd[RD_LAT-1] : 18'h2DEAD;
    assign ram_rsbe = pv[RD_LAT-1] ? ps[RD_LAT-1] : 1'b1;
    assign ram_rdbe = pv[RD_LAT-1] ? pb[RD_LAT-1] : 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectations queued on accept, compared on pop.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_vld && in_rdy) begin
                exp_q.push_back({in_dat, cur_exp});
                err_q.push_back({cur_sbe, cur_dbe});
                n_acc++;
                if (lat_arm && first_acc < 0) first_acc = cyc;
            end
            if (lat_arm && out_vld && first_out < 0) first_out = cyc;
            if (out_vld && out_rdy) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got 0x%0h with nothing outstanding", out_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dat", 32'(out_dat), 32'(e[DATA_W:1]));
                    check("out_dbe", 32'(out_dbe), 32'(e[0]));
                end
            end
            if (ram_wen) begin
                if (last_wadr == 11'd2047 && ram_wadr == 11'd0) wwrap = 1'b1;
                last_wadr = ram_wadr;
            end
            if (ram_ren) begin
                if (last_radr == 11'd2047 && ram_radr == 11'd0) rwrap = 1'b1;
                last_radr = ram_radr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic s, input logic b, input logic x);
        int g = 0;
        in_vld = 1'b1; in_dat = d; cur_sbe = s; cur_dbe = b; cur_exp = x;
        while (!in_rdy && g < 4000) begin tick(); g++; end
        if (!in_rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: in_rdy stayed 0, required 1");
        end
        tick();
    endtask

    task automatic drain(input string name, input int bound);
        int g = 0;
        while ((exp_q.size() != 0 || out_vld) && g < bound) begin tick(); g++; end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
        end
        check({name, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    typedef struct {
        logic [DATA_W-1:0] dat;
        logic              sbe;
        logic              dbe;
        logic              exp_dbe;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int sent, used, pop_a, pop_b, g;

        vecs[0] = '{18'h00001, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{18'h3FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{18'h15555, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{18'h00111, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{18'h00222, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{18'h00333, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{18'h00444, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{18'h00555, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{18'h00666, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) tick();
        check("rst_in_rdy", 32'(in_rdy), 0);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_ram_wen", 32'(ram_wen), 0);
        check("rst_ram_ren", 32'(ram_ren), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_sbe", 32'(sbe_cnt), 0);
        check("rst_dbe", 32'(dbe_seen), 0);
        rst_n = 1'b1;
        tick();
        check("rel_in_rdy", 32'(in_rdy), 1);

        // Three words back-to-back, latency and ordering
        out_rdy = 1'b1;
        lat_arm = 1'b1;
        for (int i = 0; i < 3; i++) push(vecs[i].dat, vecs[i].sbe, vecs[i].dbe, vecs[i].exp_dbe);
        in_vld = 1'b0;
        drain("basic", 50);
        lat_arm = 1'b0;
        check("first_latency", 32'(first_out - first_acc), 32'(RD_LAT + 3));

        // Fill with out_rdy low
        out_rdy = 1'b0;
        n_acc = 0;
        in_vld = 1'b1; in_dat = 18'h10000; cur_sbe = 0; cur_dbe = 0; cur_exp = 0;
        for (int i = 0; i < 2100; i++) begin
            if (in_rdy) begin tick(); in_dat = in_dat + 1'b1; end
            else tick();
        end
        in_vld = 1'b0;
        check("full_accepted", 32'(n_acc), 32'(DEPTH + OBUF));
        check("full_in_rdy", 32'(in_rdy), 0);
        check("full_occ", 32'(occupancy), 32'(DEPTH + OBUF));
        check("full_out_vld", 32'(out_vld), 1);
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        for (int k = 0; k < 2; k++) if (!in_rdy) tick();
        check("full_reopen", 32'(in_rdy), 1);
        out_rdy = 1'b1;
        drain("full", 2300);

        // Long stream with every return flagged single-bit
        force_sbe = 1'b1;
        in_vld = 1'b1; in_dat = '0;
        sent = 0; used = 0; pop_a = 0; pop_b = 0;
        while (sent < NSTREAM && used < NSTREAM + 500) begin
            if (used == 200)  pop_a = n_pop;
            if (used == 1200) pop_b = n_pop;
            if (in_rdy) begin tick(); sent++; in_dat = in_dat + 1'b1; end
            else tick();
            used++;
        end
        in_vld = 1'b0;
        drain("stream", 100);
        force_sbe = 1'b0;
        check("stream_sent", 32'(sent), 32'(NSTREAM));
        check("stream_no_stall", 32'(used), 32'(NSTREAM));
        check("stream_rate", 32'(pop_b - pop_a), 32'd1000);
        check("wadr_wrap", 32'(wwrap), 1);
        check("radr_wrap", 32'(rwrap), 1);
        check("sbe_saturated", 32'(sbe_cnt), 32'hFFFF);
        check("stream_dbe", 32'(dbe_seen), 0);

        // clr_err coinciding with a single-bit return
        push(18'h02468, 1'b1, 1'b0, 1'b0);
        in_vld = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!pv[RD_LAT-1] && g < 20);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("clr_vs_sbe", 32'(sbe_cnt), 1);
        drain("clr", 50);

        // ECC table: three sbe returns then sbe+dbe on the fifth
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("ecc_pre_sbe", 32'(sbe_cnt), 0);
        for (int i = 3; i < 9; i++) push(vecs[i].dat, vecs[i].sbe, vecs[i].dbe, vecs[i].exp_dbe);
        in_vld = 1'b0; cur_sbe = 0; cur_dbe = 0; cur_exp = 0;
        drain("ecc", 50);
        check("ecc_sbe_cnt", 32'(sbe_cnt), 3);
        check("ecc_dbe_seen", 32'(dbe_seen), 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("ecc_clr_sbe", 32'(sbe_cnt), 0);
        check("ecc_clr_dbe", 32'(dbe_seen), 0);

        // Reset with stored words and two reads in flight
        out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) push(18'h01000 + 18'(i), 1'b0, 1'b0, 1'b0);
        in_vld = 1'b0;
        repeat (10) tick();
        check("pre_rst_occ", 32'(occupancy), 12);
        out_rdy = 1'b1; tick(); tick(); out_rdy = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_occ", 32'(occupancy), 0);
        check("midrst_out_vld", 32'(out_vld), 0);
        check("midrst_in_rdy", 32'(in_rdy), 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("post_rst_out_vld", 32'(out_vld), 0);
            tick();
        end
        check("post_rst_occ", 32'(occupancy), 0);
        check("post_rst_in_rdy", 32'(in_rdy), 1);
        out_rdy = 1'b1;
        push(18'h0ABCD, 1'b0, 1'b0, 1'b0);
        in_vld = 1'b0;
        g = 0;
        while (!out_vld && g < 20) begin tick(); g++; end
        check("post_rst_first", 32'(out_dat), 32'h0ABCD);
        drain("post_rst", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
